reg_file_sb: RTL

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_pkg.sv | 15 +
 rtl/reg_file_scoreboard.sv | 60 ++++++
 rtl/reg_file_sb.sv | 80 ++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared defaults and width derivations for the scoreboarded register file.
package reg_file_pkg;

   localparam int DEF_DATA_W   = 16;
   localparam int DEF_NUM_REGS = 4;

   function automatic int addr_w(input int num_regs);
      return (num_regs <= 2) ? 1 : $clog2(num_regs);
   endfunction

   function automatic int be_w(input int data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// Busy-bit tracking for the register file: reserve sets, write completion clears,
// and a one-cycle error pulse when an already-busy register is reserved again.
module reg_file_scoreboard
   import reg_file_pkg::*;
#(
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int ZERO_REG = 0,
   localparam int ADDR_W  = addr_w(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_adr_i,
   input  logic              rsv_en_i,
   input  logic [ADDR_W-1:0] rsv_adr_i,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_adr1_i,
   input  logic [ADDR_W-1:0] rd_adr2_i,
   output logic              rd_busy1_o,
   output logic              rd_busy2_o,
   output logic              rsv_err_o
);

   logic [NUM_REGS-1:0] busy_q, busy_d;
   logic                err_d, err_q;
   logic                busy1_q, busy2_q;

   // Clear before set so a same-edge reserve beats the write completion.
   always_comb begin
      busy_d = busy_q;
      if (wr_en_i)
         busy_d[wr_adr_i] = 1'b0;
      if (rsv_en_i)
         busy_d[rsv_adr_i] = 1'b1;
      if (ZERO_REG != 0)
         busy_d[0] = 1'b0;
      err_d = rsv_en_i && busy_q[rsv_adr_i] && !(wr_en_i && (wr_adr_i == rsv_adr_i));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q  <= '0;
         err_q   <= 1'b0;
         busy1_q <= 1'b0;
         busy2_q <= 1'b0;
      end else begin
         busy_q <= busy_d;
         err_q  <= err_d;
         if (rd_en_i) begin
            busy1_q <= busy_d[rd_adr1_i];
            busy2_q <= busy_d[rd_adr2_i];
         end
      end
   end

   assign rd_busy1_o = busy1_q;
   assign rd_busy2_o = busy2_q;
   assign rsv_err_o  = err_q;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with byte-enabled writes, two registered read ports with
// write-first bypass, and a busy scoreboard for reserved registers.
module reg_file_sb
   import reg_file_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int ZERO_REG = 0,
   localparam int ADDR_W  = addr_w(NUM_REGS),
   localparam int BE_W    = be_w(DATA_W)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              write_en,
   input  logic [ADDR_W-1:0] write_adr,
   input  logic [DATA_W-1:0] write_data,
   input  logic [BE_W-1:0]   write_be,
   input  logic              read_en,
   input  logic [ADDR_W-1:0] read_adr1,
   input  logic [ADDR_W-1:0] read_adr2,
   output logic [DATA_W-1:0] read_data1,
   output logic [DATA_W-1:0] read_data2,
   output logic              read_busy1,
   output logic              read_busy2,
   input  logic              rsv_en,
   input  logic [ADDR_W-1:0] rsv_adr,
   output logic              rsv_err
);

   logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
   logic [DATA_W-1:0]               rd1_q, rd2_q;

   // regs_d is the post-write view, which also feeds the read bypass.
   always_comb begin
      regs_d = regs_q;
      if (write_en) begin
         for (int k = 0; k < BE_W; k++)
            if (write_be[k])
               regs_d[write_adr][8*k +: 8] = write_data[8*k +: 8];
      end
      if (ZERO_REG != 0)
         regs_d[0] = '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         regs_q <= '0;
         rd1_q  <= '0;
         rd2_q  <= '0;
      end else begin
         regs_q <= regs_d;
         if (read_en) begin
            rd1_q <= regs_d[read_adr1];
            rd2_q <= regs_d[read_adr2];
         end
      end
   end

   assign read_data1 = rd1_q;
   assign read_data2 = rd2_q;

   reg_file_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .clk        (clk),
      .rst_n      (reset),
      .wr_en_i    (write_en),
      .wr_adr_i   (write_adr),
      .rsv_en_i   (rsv_en),
      .rsv_adr_i  (rsv_adr),
      .rd_en_i    (read_en),
      .rd_adr1_i  (read_adr1),
      .rd_adr2_i  (read_adr2),
      .rd_busy1_o (read_busy1),
      .rd_busy2_o (read_busy2),
      .rsv_err_o  (rsv_err)
   );

endmodule
